ssd_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller. It is the generalised successor to the fixed four-digit scanner. It drives DIGITS common-anode digits from a packed hex bus and integrates the hex-to-abcdefg decode. It adds decimal points, per-digit blanking, leading-zero suppression, PWM brightness, frame-coherent input snapshots and a frame tick. It sits between the adder/multiplier result registers and the board's segment/anode pins.

---
 rtl/ssd_scan_ctrl.sv | 145 ++++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// Multiplexed seven-segment scanner: free-running prescaler and digit index,
// frame-coherent input snapshots, leading-zero suppression and PWM anode gating.
module ssd_scan_ctrl #(
    parameter int DIGITS      = 4,
    parameter int DIV_BITS    = 16,
    parameter int BRIGHT_BITS = 3
) (
    input  logic                        stateClk,
    input  logic                        rst,
    input  logic [4*DIGITS-1:0]         hex,
    input  logic [DIGITS-1:0]           dp,
    input  logic [DIGITS-1:0]           blank,
    input  logic                        lzs,
    input  logic [BRIGHT_BITS-1:0]      bright,
    output logic [6:0]                  seg,
    output logic                        dpo,
    output logic [DIGITS-1:0]           an,
    output logic [$clog2(DIGITS)-1:0]   digit_sel,
    output logic                        frame_tick
);

    localparam int SEL_W = $clog2(DIGITS);
    localparam logic [SEL_W-1:0] LAST = SEL_W'(DIGITS - 1);

    logic [DIV_BITS-1:0]    cnt;
    logic [SEL_W-1:0]       idx;
    logic [4*DIGITS-1:0]    hex_s;
    logic [DIGITS-1:0]      dp_s;
    logic [DIGITS-1:0]      blank_s;
    logic                   lzs_s;
    logic [BRIGHT_BITS-1:0] bright_s;
    logic                   frame_end_d;

    logic                   cnt_wrap;
    logic                   frame_end;
    logic [3:0]             nib;
    logic                   dp_cur;
    logic                   blank_cur;
    logic                   lz_cur;
    logic                   lz_chain;
    logic [DIGITS-1:0]      onehot;
    logic                   suppressed;
    logic [BRIGHT_BITS-1:0] top;
    logic                   lit;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0:    decode = 7'b0000001;
            4'h1:    decode = 7'b1001111;
            4'h2:    decode = 7'b0010010;
            4'h3:    decode = 7'b0000110;
            4'h4:    decode = 7'b1001100;
            4'h5:    decode = 7'b0100100;
            4'h6:    decode = 7'b0100000;
            4'h7:    decode = 7'b0001111;
            4'h8:    decode = 7'b0000000;
            4'h9:    decode = 7'b0000100;
            4'hA:    decode = 7'b0001000;
            4'hB:    decode = 7'b1100000;
            4'hC:    decode = 7'b0110001;
            4'hD:    decode = 7'b1000010;
            4'hE:    decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    assign cnt_wrap  = &cnt;
    assign frame_end = cnt_wrap && (idx == LAST);

    // lz_chain walks from the most significant digit down, so at digit k it
    // is set only when nibbles k..DIGITS-1 are all zero.
    always_comb begin
        nib       = 4'h0;
        dp_cur    = 1'b0;
        blank_cur = 1'b0;
        lz_cur    = 1'b0;
        lz_chain  = 1'b1;
        onehot    = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lz_chain = lz_chain && (hex_s[4*k +: 4] == 4'h0);
            if (idx == SEL_W'(k)) begin
                nib       = hex_s[4*k +: 4];
                dp_cur    = dp_s[k];
                blank_cur = blank_s[k];
                lz_cur    = lz_chain;
                onehot[k] = 1'b1;
            end
        end
    end

    assign suppressed = lzs_s && (idx != '0) && lz_cur;
    assign top        = cnt[DIV_BITS-1 -: BRIGHT_BITS];
    assign lit        = (top <= bright_s);

    always_ff @(posedge stateClk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            idx         <= '0;
            hex_s       <= '0;
            dp_s        <= '0;
            blank_s     <= '0;
            lzs_s       <= 1'b0;
            bright_s    <= '0;
            frame_end_d <= 1'b0;
        end else begin
            cnt         <= cnt + 1'b1;
            frame_end_d <= frame_end;
            if (cnt_wrap)
                idx <= (idx == LAST) ? '0 : idx + 1'b1;
            if (frame_end) begin
                hex_s    <= hex;
                dp_s     <= dp;
                blank_s  <= blank;
                lzs_s    <= lzs;
                bright_s <= bright;
            end
        end
    end

    // Blanked and suppressed digits keep their anode slot so scan timing is uniform.
    always_ff @(posedge stateClk or posedge rst) begin
        if (rst) begin
            seg        <= 7'b1111111;
            dpo        <= 1'b1;
            an         <= '1;
            digit_sel  <= '0;
            frame_tick <= 1'b0;
        end else begin
            if (blank_cur) begin
                seg <= 7'b1111111;
                dpo <= 1'b1;
            end else if (suppressed) begin
                seg <= 7'b1111111;
                dpo <= ~dp_cur;
            end else begin
                seg <= decode(nib);
                dpo <= ~dp_cur;
            end
            an         <= lit ? ~onehot : '1;
            digit_sel  <= idx;
            frame_tick <= frame_end_d;
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: a 4-digit and a 3-digit instance (DIV_BITS=4, BRIGHT_BITS=2)
// compared every cycle against a time-based model of the scan, plus directed pattern checks.
module tb_ssd_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hex;
    logic [3:0]  dp, blank;
    logic        lzs;
    logic [1:0]  bright;

    logic [6:0]  seg4, seg3;
    logic        dpo4, dpo3, ft4, ft3;
    logic [3:0]  an4;
    logic [2:0]  an3;
    logic [1:0]  sel4, sel3;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ssd_scan_ctrl #(.DIGITS(4), .DIV_BITS(4), .BRIGHT_BITS(2)) u4 (
        .stateClk(clk), .rst(rst), .hex(hex), .dp(dp), .blank(blank), .lzs(lzs),
        .bright(bright), .seg(seg4), .dpo(dpo4), .an(an4), .digit_sel(sel4), .frame_tick(ft4));

    ssd_scan_ctrl #(.DIGITS(3), .DIV_BITS(4), .BRIGHT_BITS(2)) u3 (
        .stateClk(clk), .rst(rst), .hex(hex[11:0]), .dp(dp[2:0]), .blank(blank[2:0]), .lzs(lzs),
        .bright(bright), .seg(seg3), .dpo(dpo3), .an(an3), .digit_sel(sel3), .frame_tick(ft3));

    typedef struct packed {
        logic [15:0] h;
        logic [3:0]  d;
        logic [3:0]  b;
        logic        l;
        logic [1:0]  br;
    } in_t;

    logic [6:0] seg_tbl [16];
    initial seg_tbl = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    localparam logic [14:0] RST_EXP = {7'h7F, 1'b1, 4'hF, 2'b00, 1'b0};

    // Outputs after edge n+1 reflect the state after n edges: cnt=n%16, idx=(n/16)%D.
    function automatic logic [14:0] model(int dn, in_t s, int n);
        int c, i, nib;
        logic [6:0] sg;
        logic dpo_e, ft;
        logic [3:0] an_e;
        c   = n % 16;
        i   = (n / 16) % dn;
        nib = int'((s.h >> (4 * i)) & 16'hF);
        ft  = (n % (16 * dn) == 0) && (n > 0);
        an_e = ((c / 4) <= int'(s.br)) ? ~(4'b0001 << i) : 4'hF;
        if (s.b[i]) begin
            sg = 7'h7F; dpo_e = 1'b1;
        end else if (s.l && i >= 1 && (s.h >> (4 * i)) == 16'h0) begin
            sg = 7'h7F; dpo_e = ~s.d[i];
        end else begin
            sg = seg_tbl[nib]; dpo_e = ~s.d[i];
        end
        return {sg, dpo_e, an_e, 2'(i), ft};
    endfunction

    int          n;
    in_t         snap4, snap3;
    logic [14:0] exp4, exp3;
    logic [14:0] act4, act3;

    assign act4 = {seg4, dpo4, an4, sel4, ft4};
    assign act3 = {seg3, dpo3, 1'b1, an3, sel3, ft3};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            n     <= 0;
            snap4 <= '0;
            snap3 <= '0;
            exp4  <= RST_EXP;
            exp3  <= RST_EXP;
        end else begin
            exp4 <= model(4, snap4, n);
            exp3 <= model(3, snap3, n);
            if ((n + 1) % 64 == 0) snap4 <= {hex, dp, blank, lzs, bright};
            if ((n + 1) % 48 == 0) snap3 <= {4'h0, hex[11:0], 1'b0, dp[2:0], 1'b0, blank[2:0], lzs, bright};
            n <= n + 1;
        end
    end

    task automatic wait_ft4(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (ft4) begin ok = 1'b1; return; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; hex = '0; dp = '0; blank = '0; lzs = 1'b0; bright = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (act4 !== RST_EXP) begin failures++; $display("FAIL reset4 got=%h exp=%h", act4, RST_EXP); end
        checks++;
        if (act3 !== RST_EXP) begin failures++; $display("FAIL reset3 got=%h exp=%h", act3, RST_EXP); end
        rst = 1'b0;
        repeat (70) begin
            @(negedge clk);
            checks++;
            if (act4 !== exp4) begin failures++; $display("FAIL first_frame4 got=%h exp=%h t=%0t", act4, exp4, $time); end
            checks++;
            if (act3 !== exp3) begin failures++; $display("FAIL first_frame3 got=%h exp=%h t=%0t", act3, exp3, $time); end
        end
    endtask

    task automatic test_basic();
        logic [6:0] want_seg [4];
        logic [3:0] want_an  [4];
        bit ok;
        want_seg = '{7'b0111000, 7'b0000110, 7'b0001000, 7'b1001111};
        want_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        bright = 2'd3; hex = 16'h1A3F; lzs = 1'b0; dp = '0; blank = '0;
        wait_ft4(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL basic_tick got=none exp=frame_tick"); end
        for (int j = 0; j < 128; j++) begin
            if (j % 16 == 0 && j < 64) begin
                checks++;
                if (seg4 !== want_seg[j/16] || an4 !== want_an[j/16])
                    begin failures++; $display("FAIL basic_digit%0d got=%b/%b exp=%b/%b", j/16, seg4, an4, want_seg[j/16], want_an[j/16]); end
            end
            checks++;
            if (act4 !== exp4) begin failures++; $display("FAIL basic4 got=%h exp=%h t=%0t", act4, exp4, $time); end
            checks++;
            if (act3 !== exp3) begin failures++; $display("FAIL basic3 got=%h exp=%h t=%0t", act3, exp3, $time); end
            @(negedge clk);
        end
    endtask

    task automatic test_lzs();
        logic [6:0] want_a [4];
        logic [6:0] want_b [4];
        bit ok;
        want_a = '{7'b0000001, 7'b0100100, 7'h7F, 7'h7F};
        want_b = '{7'b0000001, 7'h7F, 7'h7F, 7'h7F};
        lzs = 1'b1; hex = 16'h0050; bright = 2'd3;
        for (int pass = 0; pass < 2; pass++) begin
            wait_ft4(ok);
            checks++;
            if (!ok) begin failures++; $display("FAIL lzs_tick got=none exp=frame_tick"); end
            for (int j = 0; j < 64; j++) begin
                if (j % 16 == 0) begin
                    checks++;
                    if (seg4 !== (pass == 0 ? want_a[j/16] : want_b[j/16]))
                        begin failures++; $display("FAIL lzs_digit%0d got=%b exp=%b", j/16, seg4, pass == 0 ? want_a[j/16] : want_b[j/16]); end
                end
                checks++;
                if (act4 !== exp4) begin failures++; $display("FAIL lzs4 got=%h exp=%h t=%0t", act4, exp4, $time); end
                checks++;
                if (act3 !== exp3) begin failures++; $display("FAIL lzs3 got=%h exp=%h t=%0t", act3, exp3, $time); end
                @(negedge clk);
            end
            hex = 16'h0000;
        end
        lzs = 1'b0;
    endtask

    task automatic test_bright();
        int lit4, lit3;
        bit ok;
        bright = 2'd1; hex = 16'h8421;
        wait_ft4(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL bright_tick got=none exp=frame_tick"); end
        repeat (64) @(negedge clk);
        lit4 = 0; lit3 = 0;
        for (int j = 0; j < 192; j++) begin
            if (an4 !== 4'hF) lit4++;
            if (an3 !== 3'h7) lit3++;
            checks++;
            if (act4 !== exp4) begin failures++; $display("FAIL bright4 got=%h exp=%h t=%0t", act4, exp4, $time); end
            checks++;
            if (act3 !== exp3) begin failures++; $display("FAIL bright3 got=%h exp=%h t=%0t", act3, exp3, $time); end
            @(negedge clk);
        end
        checks++;
        if (lit4 != 96) begin failures++; $display("FAIL bright_duty4 got=%0d exp=96", lit4); end
        checks++;
        if (lit3 != 96) begin failures++; $display("FAIL bright_duty3 got=%0d exp=96", lit3); end
    endtask

    task automatic test_mid_frame();
        bit ok, seen;
        bright = 2'd3; hex = 16'h1234; dp = '0; blank = '0;
        wait_ft4(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL mid_tick got=none exp=frame_tick"); end
        repeat (20) @(negedge clk);
        hex = 16'hABCD;
        seen = 1'b0;
        for (int j = 0; j < 80 && !seen; j++) begin
            @(negedge clk);
            checks++;
            if (ft4) begin
                seen = 1'b1;
                if (seg4 !== 7'b1000010) begin failures++; $display("FAIL mid_new got=%b exp=1000010", seg4); end
            end else if (seg4 !== seg_tbl[4 - int'(sel4)]) begin
                failures++; $display("FAIL mid_old got=%b exp=%b", seg4, seg_tbl[4 - int'(sel4)]);
            end
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL mid_tick2 got=none exp=frame_tick"); end
    endtask

    task automatic test_dp_blank();
        bit ok;
        hex = 16'h1A3F; dp = 4'b0110; blank = 4'b0010; bright = 2'd3; lzs = 1'b0;
        wait_ft4(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL dpb_tick got=none exp=frame_tick"); end
        for (int j = 0; j < 64; j++) begin
            if (j == 16) begin
                checks++;
                if (seg4 !== 7'h7F || dpo4 !== 1'b1) begin failures++; $display("FAIL dpb_blank got=%b/%b exp=1111111/1", seg4, dpo4); end
            end
            if (j == 32) begin
                checks++;
                if (dpo4 !== 1'b0) begin failures++; $display("FAIL dpb_dp got=%b exp=0", dpo4); end
            end
            checks++;
            if (act4 !== exp4) begin failures++; $display("FAIL dpb4 got=%h exp=%h t=%0t", act4, exp4, $time); end
            checks++;
            if (act3 !== exp3) begin failures++; $display("FAIL dpb3 got=%h exp=%h t=%0t", act3, exp3, $time); end
            @(negedge clk);
        end
        dp = '0; blank = '0;
    endtask

    task automatic test_digits3();
        int period, illegal;
        bit seen;
        logic [1:0] want_sel [4];
        want_sel = '{2'd0, 2'd1, 2'd2, 2'd0};
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk);
            if (ft3) seen = 1'b1;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL d3_tick got=none exp=frame_tick"); end
        period = 0; illegal = 0; seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            if (k % 16 == 0 && k < 64) begin
                checks++;
                if (sel3 !== want_sel[k/16]) begin failures++; $display("FAIL d3_sel got=%0d exp=%0d", sel3, want_sel[k/16]); end
            end
            if (!(an3 inside {3'b111, 3'b110, 3'b101, 3'b011})) illegal++;
            @(negedge clk);
            period++;
            if (ft3) seen = 1'b1;
        end
        checks++;
        if (period != 48) begin failures++; $display("FAIL d3_period got=%0d exp=48", period); end
        checks++;
        if (illegal != 0) begin failures++; $display("FAIL d3_an_illegal got=%0d exp=0", illegal); end
    endtask

    task automatic test_random();
        for (int j = 0; j < 1500; j++) begin
            if ($urandom_range(0, 15) == 0) begin
                hex    = 16'($urandom);
                if ($urandom_range(0, 1) == 1) hex = hex & 16'h00FF;
                dp     = 4'($urandom);
                blank  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                lzs    = 1'($urandom);
                bright = 2'($urandom);
            end
            @(negedge clk);
            checks++;
            if (act4 !== exp4) begin failures++; $display("FAIL rand4 got=%h exp=%h t=%0t", act4, exp4, $time); end
            checks++;
            if (act3 !== exp3) begin failures++; $display("FAIL rand3 got=%h exp=%h t=%0t", act3, exp3, $time); end
        end
    endtask

    task automatic test_rst_mid();
        hex = 16'h9F2E; bright = 2'd3; lzs = 1'b0;
        repeat (37) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (act4 !== RST_EXP) begin failures++; $display("FAIL rst_mid4 got=%h exp=%h", act4, RST_EXP); end
        checks++;
        if (act3 !== RST_EXP) begin failures++; $display("FAIL rst_mid3 got=%h exp=%h", act3, RST_EXP); end
        @(negedge clk);
        rst = 1'b0;
        repeat (80) begin
            @(negedge clk);
            checks++;
            if (act4 !== exp4) begin failures++; $display("FAIL rst_restart4 got=%h exp=%h t=%0t", act4, exp4, $time); end
            checks++;
            if (act3 !== exp3) begin failures++; $display("FAIL rst_restart3 got=%h exp=%h t=%0t", act3, exp3, $time); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lzs();
        test_bright();
        test_mid_frame();
        test_dp_blank();
        test_digits3();
        test_random();
        test_rst_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
